// File: rtl/pipelined_regfile_alu_3stage_pkg.sv
// Shared definitions for the 3-stage regfile/ALU pipeline: ALU opcodes,
// instruction field positions and the NOP encoding.
package pipe3_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOT  = 3'b101,
    ALU_SHL  = 3'b110,
    ALU_PASS = 3'b111
  } aluop_e;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned WA_LSB  = 9;
  localparam int unsigned RA1_LSB = 5;
  localparam int unsigned RA2_LSB = 1;
  localparam int unsigned WEN_BIT = 0;
  localparam int unsigned FIELD_W = 4;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

endpackage

// File: rtl/pipelined_regfile_alu_3stage_alu.sv
// Combinational ALU for the EXE stage; all results wrap modulo 2^DATA_W.
module alu_n
  import pipe3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        aluop,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (aluop)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOT:  y = ~a;
      ALU_SHL:  y = a << 1;
      ALU_PASS: y = a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_regfile_alu_3stage.sv
// Fetch / decode+read / execute / writeback pipeline with EXE->ID and WB->ID
// forwarding, hardwired-zero r0 and a global stall.
module pipelined_regfile_alu_3stage
  import pipe3_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned PC_W   = 16,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [15:0]         instr_i,
  output logic [PC_W-1:0]     pc_o,
  output logic [15:0]         inst_id_o,
  output logic [DATA_W-1:0]   rdata1_o,
  output logic [DATA_W-1:0]   rdata2_o,
  output logic [DATA_W-1:0]   rdata1_ex_o,
  output logic [DATA_W-1:0]   rdata2_ex_o,
  output logic [2:0]          aluop_ex_o,
  output logic [AW-1:0]       waddr_ex_o,
  output logic [DATA_W-1:0]   aluout_o,
  output logic                wb_en_o,
  output logic [AW-1:0]       wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o
);

  logic [PC_W-1:0]    pc;
  logic [15:0]        inst_id;
  logic [DATA_W-1:0]  rf [NREGS];

  logic [FIELD_W-1:0] waddr_f, raddr1_f, raddr2_f;
  logic [2:0]         aluop_id;
  logic [AW-1:0]      waddr_id, raddr1_id, raddr2_id;
  logic               wen_id;
  logic [DATA_W-1:0]  rdata1, rdata2;

  logic [DATA_W-1:0]  rdata1_ex, rdata2_ex;
  logic [2:0]         aluop_ex;
  logic [AW-1:0]      waddr_ex;
  logic               wen_ex;
  logic [DATA_W-1:0]  aluout;

  logic               wb_en;
  logic [AW-1:0]      wb_addr;
  logic [DATA_W-1:0]  wb_data;

  assign aluop_id  = inst_id[OP_LSB +: 3];
  assign waddr_f   = inst_id[WA_LSB +: FIELD_W];
  assign raddr1_f  = inst_id[RA1_LSB +: FIELD_W];
  assign raddr2_f  = inst_id[RA2_LSB +: FIELD_W];
  assign wen_id    = inst_id[WEN_BIT];
  assign waddr_id  = waddr_f[AW-1:0];
  assign raddr1_id = raddr1_f[AW-1:0];
  assign raddr2_id = raddr2_f[AW-1:0];

  // Youngest producer wins: EXE result beats the pending WB write, which
  // beats the regfile; r0 short-circuits everything.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [AW-1:0]     ra,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_wen,
    input logic [AW-1:0]     ex_addr,
    input logic [DATA_W-1:0] ex_val,
    input logic              wb_wen,
    input logic [AW-1:0]     wb_a,
    input logic [DATA_W-1:0] wb_val
  );
    if (ra == '0)                          return '0;
    else if (ex_wen && (ex_addr == ra))    return ex_val;
    else if (wb_wen && (wb_a == ra))       return wb_val;
    else                                   return rf_val;
  endfunction

  always_comb begin
    rdata1 = fwd(raddr1_id, rf[raddr1_id], wen_ex, waddr_ex, aluout, wb_en, wb_addr, wb_data);
    rdata2 = fwd(raddr2_id, rf[raddr2_id], wen_ex, waddr_ex, aluout, wb_en, wb_addr, wb_data);
  end

  alu_n #(.DATA_W(DATA_W)) u_alu (
    .a     (rdata1_ex),
    .b     (rdata2_ex),
    .aluop (aluop_ex),
    .y     (aluout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      inst_id   <= NOP;
      rdata1_ex <= '0;
      rdata2_ex <= '0;
      aluop_ex  <= '0;
      waddr_ex  <= '0;
      wen_ex    <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else if (!stall) begin
      pc        <= pc + PC_W'(1);
      inst_id   <= instr_i;
      rdata1_ex <= rdata1;
      rdata2_ex <= rdata2;
      aluop_ex  <= aluop_id;
      waddr_ex  <= waddr_id;
      wen_ex    <= wen_id;
      wb_en     <= wen_ex && (waddr_ex != '0);
      wb_addr   <= waddr_ex;
      wb_data   <= aluout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= DATA_W'(i);
    end else if (!stall && wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign pc_o        = pc;
  assign inst_id_o   = inst_id;
  assign rdata1_o    = rdata1;
  assign rdata2_o    = rdata2;
  assign rdata1_ex_o = rdata1_ex;
  assign rdata2_ex_o = rdata2_ex;
  assign aluop_ex_o  = aluop_ex;
  assign waddr_ex_o  = waddr_ex;
  assign aluout_o    = aluout;
  assign wb_en_o     = wb_en;
  assign wb_addr_o   = wb_addr;
  assign wb_data_o   = wb_data;

endmodule

// File: tb/tb_pipelined_regfile_alu_3stage.sv
// Directed, table-driven bench for the 3-stage regfile/ALU pipeline plus a
// reduced-width instance for wrap-around behaviour.
module tb_pipelined_regfile_alu_3stage;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SHL = 3'd6, OP_PASS = 3'd7;

  logic clk = 1'b0;
  logic rst;
  logic stall;

  // main instance (16/16/16)
  logic [15:0] instr, pc, inst_id, rd1, rd2, rd1_ex, rd2_ex, aluout, wb_data;
  logic [2:0]  aluop_ex;
  logic [3:0]  waddr_ex, wb_addr;
  logic        wb_en;

  // small instance (8/8/4)
  logic [15:0] instr2, inst_id2;
  logic [3:0]  pc2;
  logic [7:0]  rd1_2, rd2_2, rd1_ex2, rd2_ex2, aluout2, wb_data2;
  logic [2:0]  aluop_ex2, waddr_ex2, wb_addr2;
  logic        wb_en2;

  logic [15:0] imem  [64];
  logic [15:0] imem2 [16];
  logic [15:0] prog  [64];

  assign instr  = imem[pc[5:0]];
  assign instr2 = imem2[pc2];

  always #5 clk = ~clk;

  pipelined_regfile_alu_3stage #(.DATA_W(16), .NREGS(16), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_i(instr),
    .pc_o(pc), .inst_id_o(inst_id), .rdata1_o(rd1), .rdata2_o(rd2),
    .rdata1_ex_o(rd1_ex), .rdata2_ex_o(rd2_ex), .aluop_ex_o(aluop_ex),
    .waddr_ex_o(waddr_ex), .aluout_o(aluout), .wb_en_o(wb_en),
    .wb_addr_o(wb_addr), .wb_data_o(wb_data)
  );

  pipelined_regfile_alu_3stage #(.DATA_W(8), .NREGS(8), .PC_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .instr_i(instr2),
    .pc_o(pc2), .inst_id_o(inst_id2), .rdata1_o(rd1_2), .rdata2_o(rd2_2),
    .rdata1_ex_o(rd1_ex2), .rdata2_ex_o(rd2_ex2), .aluop_ex_o(aluop_ex2),
    .waddr_ex_o(waddr_ex2), .aluout_o(aluout2), .wb_en_o(wb_en2),
    .wb_addr_o(wb_addr2), .wb_data_o(wb_data2)
  );

  typedef struct {
    logic        stall;
    logic [15:0] pc;
    logic [15:0] id;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] alu;
    logic        wb_en;
    logic [15:0] wb_data;
  } vec_t;

  vec_t base [17];
  vec_t cur  [20];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] enc(input logic [2:0] op, input int unsigned wa,
                                      input int unsigned ra1, input int unsigned ra2,
                                      input logic wen);
    return {op, 4'(wa), 4'(ra1), 4'(ra2), wen};
  endfunction

  function automatic vec_t mk(input logic [15:0] r1, input logic [15:0] r2,
                              input logic [15:0] alu, input logic wbe,
                              input logic [15:0] wbd);
    vec_t v;
    v.stall = 1'b0; v.pc = '0; v.id = '0;
    v.r1 = r1; v.r2 = r2; v.alu = alu; v.wb_en = wbe; v.wb_data = wbd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_prog;
    for (int i = 0; i < 64; i++) imem[i] = prog[i];
  endtask

  task automatic run_table(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      stall = cur[k].stall;
      #1;
      chk($sformatf("%s[%0d] pc", tag, k), 32'(pc), 32'(cur[k].pc));
      chk($sformatf("%s[%0d] inst_id", tag, k), 32'(inst_id), 32'(cur[k].id));
      chk($sformatf("%s[%0d] rdata1", tag, k), 32'(rd1), 32'(cur[k].r1));
      chk($sformatf("%s[%0d] rdata2", tag, k), 32'(rd2), 32'(cur[k].r2));
      chk($sformatf("%s[%0d] aluout", tag, k), 32'(aluout), 32'(cur[k].alu));
      chk($sformatf("%s[%0d] wb_en", tag, k), 32'(wb_en), 32'(cur[k].wb_en));
      if (cur[k].wb_en)
        chk($sformatf("%s[%0d] wb_data", tag, k), 32'(wb_data), 32'(cur[k].wb_data));
      @(negedge clk);
    end
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
    for (int i = 0; i < 16; i++) imem2[i] = 16'h0000;

    // independent ops, forward chain (dist 1,1,2,3), r0 write, then regfile reads
    prog[0]  = enc(OP_ADD, 3, 1, 2, 1'b1);
    prog[1]  = enc(OP_XOR, 4, 6, 7, 1'b1);
    prog[2]  = enc(OP_ADD, 5, 3, 4, 1'b1);
    prog[3]  = enc(OP_ADD, 3, 1, 2, 1'b1);
    prog[4]  = enc(OP_ADD, 4, 3, 3, 1'b1);
    prog[5]  = enc(OP_SUB, 5, 4, 1, 1'b1);
    prog[6]  = enc(OP_ADD, 6, 4, 3, 1'b1);
    prog[7]  = enc(OP_ADD, 0, 1, 2, 1'b1);
    prog[8]  = enc(OP_ADD, 8, 0, 2, 1'b1);
    prog[9]  = enc(OP_PASS, 9, 8, 0, 1'b1);
    prog[10] = enc(OP_AND, 13, 6, 7, 1'b0);
    prog[11] = enc(OP_SHL, 14, 7, 0, 1'b0);
    prog[12] = enc(OP_OR, 10, 3, 4, 1'b0);
    prog[13] = enc(OP_ADD, 11, 5, 6, 1'b0);
    prog[14] = enc(OP_XOR, 12, 8, 5, 1'b0);

    //             rdata1 rdata2 aluout wb_en wb_data
    base[0]  = mk(16'd0, 16'd0, 16'd0,  1'b0, 16'd0);
    base[1]  = mk(16'd1, 16'd2, 16'd0,  1'b0, 16'd0);
    base[2]  = mk(16'd6, 16'd7, 16'd3,  1'b0, 16'd0);
    base[3]  = mk(16'd3, 16'd1, 16'd1,  1'b1, 16'd3);
    base[4]  = mk(16'd1, 16'd2, 16'd4,  1'b1, 16'd1);
    base[5]  = mk(16'd3, 16'd3, 16'd3,  1'b1, 16'd4);
    base[6]  = mk(16'd6, 16'd1, 16'd6,  1'b1, 16'd3);
    base[7]  = mk(16'd6, 16'd3, 16'd5,  1'b1, 16'd6);
    base[8]  = mk(16'd1, 16'd2, 16'd9,  1'b1, 16'd5);
    base[9]  = mk(16'd0, 16'd2, 16'd3,  1'b1, 16'd9);
    base[10] = mk(16'd2, 16'd0, 16'd2,  1'b0, 16'd0);
    base[11] = mk(16'd9, 16'd7, 16'd2,  1'b1, 16'd2);
    base[12] = mk(16'd7, 16'd0, 16'd1,  1'b1, 16'd2);
    base[13] = mk(16'd3, 16'd6, 16'd14, 1'b0, 16'd0);
    base[14] = mk(16'd5, 16'd9, 16'd7,  1'b0, 16'd0);
    base[15] = mk(16'd2, 16'd5, 16'd14, 1'b0, 16'd0);
    base[16] = mk(16'd0, 16'd0, 16'd7,  1'b0, 16'd0);
    for (int k = 0; k < 17; k++) begin
      base[k].pc = 16'(k);
      base[k].id = (k == 0) ? 16'h0000 : prog[k-1];
    end

    // unstalled run
    load_prog();
    for (int k = 0; k < 17; k++) cur[k] = base[k];
    do_reset();
    run_table(17, "run");

    // stall held through cycles 5..7: row 5 repeats three times, then resumes
    load_prog();
    for (int k = 0; k < 20; k++) begin
      cur[k] = base[(k < 5) ? k : (k < 9) ? 5 : k - 3];
      cur[k].stall = (k >= 5 && k <= 7);
    end
    do_reset();
    run_table(20, "stall");

    // async reset mid-stream while a WB write (r5 <= 4) is pending
    load_prog();
    do_reset();
    repeat (5) @(negedge clk);
    #1;
    chk("pre-reset wb_en", 32'(wb_en), 32'd1);
    chk("pre-reset wb_data", 32'(wb_data), 32'd4);
    #1;
    rst = 1'b1;
    #1;
    chk("async pc", 32'(pc), 32'd0);
    chk("async inst_id", 32'(inst_id), 32'd0);
    chk("async aluout", 32'(aluout), 32'd0);
    chk("async wb_en", 32'(wb_en), 32'd0);
    chk("async rdata1_ex", 32'(rd1_ex), 32'd0);
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
    prog[0] = enc(OP_PASS, 1, 4, 0, 1'b0);
    prog[1] = enc(OP_PASS, 1, 5, 0, 1'b0);
    prog[2] = enc(OP_PASS, 1, 3, 0, 1'b0);
    load_prog();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset pc0", 32'(pc), 32'd0);
    @(negedge clk); #1;
    chk("post-reset r4", 32'(rd1), 32'd4);
    @(negedge clk); #1;
    chk("post-reset r5", 32'(rd1), 32'd5);
    chk("post-reset pc2", 32'(pc), 32'd2);
    @(negedge clk); #1;
    chk("post-reset r3", 32'(rd1), 32'd3);
    chk("post-reset alu r5", 32'(aluout), 32'd5);

    // reduced-width instance: 8'hFF+1 wraps, address field truncation, PC wrap
    imem2[0] = enc(OP_NOT, 3, 0, 0, 1'b1);
    imem2[1] = enc(OP_ADD, 4, 3, 1, 1'b1);
    imem2[2] = enc(OP_PASS, 6, 9, 0, 1'b1);
    imem2[3] = enc(OP_SUB, 7, 0, 1, 1'b1);
    imem2[4] = enc(OP_SHL, 5, 3, 0, 1'b0);
    do_reset();
    for (int k = 0; k < 18; k++) begin
      #1;
      chk($sformatf("small[%0d] pc", k), 32'(pc2), 32'(k % 16));
      case (k)
        2: chk("small not", 32'(aluout2), 32'hFF);
        3: begin
             chk("small ff+1", 32'(aluout2), 32'h00);
             chk("small wb_data", 32'(wb_data2), 32'hFF);
             chk("small wb_en", 32'(wb_en2), 32'd1);
           end
        4: chk("small addr trunc", 32'(aluout2), 32'h01);
        5: chk("small 0-1", 32'(aluout2), 32'hFF);
        6: chk("small shl", 32'(aluout2), 32'hFE);
        default: ;
      endcase
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_regfile_alu_3stage.md
# pipelined_regfile_alu_3stage

Parametrised successor to the team's 2-stage regfile/ALU pipeline: a fetch / decode+read / execute / writeback datapath that actually commits ALU results back to the register file. It adds EXE→ID and WB→ID operand forwarding, a hardwired-zero r0, a global stall input, and parametrised data width, register count and PC width. It sits between the instruction memory (external, combinational read) and the debug/trace taps used by the CPU benches.

## Interface
- DATA_W, 16: datapath and register width.
- NREGS, 16: register count. Power of two, 4..16; AW = clog2(NREGS).
- PC_W, 16: program counter width.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze PC, all pipeline registers and regfile writes.
- instr_i  in  16  instruction at pc_o, combinational from imem.
- pc_o  out  PC_W  fetch address.
- inst_id_o  out  16  IF/ID instruction register.
- rdata1_o, rdata2_o  out  DATA_W  forwarded ID-stage operands.
- rdata1_ex_o, rdata2_ex_o  out  DATA_W  ID/EXE operand registers.
- aluop_ex_o  out  3  ID/EXE aluop.
- waddr_ex_o  out  AW  ID/EXE destination.
- aluout_o  out  DATA_W  combinational ALU result in EXE.
- wb_en_o, wb_addr_o (AW), wb_data_o (DATA_W)  out  EXE/WB register contents (the write being committed).

## Operation
- Instruction format: [15:13] aluop, [12:9] waddr, [8:5] raddr1, [4:1] raddr2, [0] wen. Address fields use their low AW bits.
- aluop:
  - 000 add; 001 sub (a-b); 010 and; 011 or; 100 xor; 101 not a; 110 a<<1; 111 pass a.
  - Results wrap modulo 2^DATA_W; no flags.
- Register file: NREGS×DATA_W. On rst, register i = i (truncated to DATA_W); r0 = 0.
  - r0 always reads 0; writes to r0 are dropped, and wb_en_o reads 0 for them.
- Write: at the rising edge ending the WB cycle when wb_en_o=1 and stall=0.
- ID operand select for each port, in priority order:
  1. raddr==0 → 0.
  2. EXE instruction has wen=1 and waddr==raddr → aluout_o.
  3. WB has wb_en_o=1 and wb_addr_o==raddr → wb_data_o.
  4. Otherwise the register file.
- No load/branch ops, so no data hazard stalls.
- PC increments by 1 per unstalled cycle and wraps from 2^PC_W−1 to 0.
- stall=1: PC, IF/ID, ID/EXE and EXE/WB hold; no regfile write. Forwarding muxes keep operating, so outputs are stable. Release resumes with no loss or duplication.
- Reset mid-operation: all state returns to reset values immediately; in-flight instructions are discarded and none are written.

## Timing
- Reset values:
  - pc_o=0; inst_id_o=0.
  - ID/EXE and EXE/WB registers all 0, so wb_en_o=0 (pipeline filled with NOPs).
  - aluout_o = 0+0 = 0.
  - rdata*_o follow the forwarding rules for a decoded instruction of 0, giving 0.
- Instruction fetched at PC N in cycle t:
  - in IF/ID during t+1 (operands read);
  - in ID/EXE during t+2 (aluout_o valid);
  - in EXE/WB during t+3; written at the end of t+3; visible from the regfile in t+4.
- Back-to-back dependents need no bubbles. Distance 1 uses the EXE forward, distance 2 the WB forward, distance ≥3 the regfile.
- A stall asserted in cycle t freezes state at the edge ending t.

## Structure
- Package pipe3_pkg:
  - aluop localparams (ALU_ADD … ALU_PASS);
  - instruction field positions;
  - NOP encoding 16'h0000.
- Sub-module alu_n: parametrised DATA_W, combinational, (a, b, aluop) → y.
- Regfile, forwarding and pipeline registers live in the top module.

## Test plan
- Reset release:
  - pc_o counts 0,1,2,…;
  - aluout_o=0 and wb_en_o=0 until the first instruction reaches EXE/WB;
  - r5 reads 5.
- Independent ops: ADD r3←r1,r2 then XOR r4←r6,r7 at PCs 0,1 → aluout_o=3 in cycle 2 and 1 in cycle 3; r3=3, r4=1 after writeback.
- Forward chain: ADD r3←r1,r2; ADD r4←r3,r3; SUB r5←r4,r1; ADD r6←r4,r3 (distances 1, 1, 2 and 3) → aluout_o = 3, 6, 5, 9 on consecutive cycles with no bubbles.
- r0: ADD r0←r1,r2 then ADD r8←r0,r2 → wb_en_o=0 for the first; r8=2.
- Stall: stall high 3 cycles mid-chain → all outputs frozen, no regfile change; after release the final values equal the unstalled run.
- Async reset asserted mid-stream (not clock-aligned) → outputs reset immediately; the in-flight WB write is suppressed and register contents return to i. Also repeat with DATA_W=8, NREGS=8 and PC_W=4: PC wraps 15→0 and 8'hFF+1 gives 0.
